// File: rtl/pll_reset_sequencer_if.sv
// PLL-side signal bundle for pll_reset_sequencer.
// master: the sequencer (drives the PLL reset and the system reset).
// slave : the PLL / consumer side (drives the lock indication).
interface pll_reset_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: runs on the free-running PLL reference clock, pulses
// the PLL reset, waits for a debounced lock, holds the system reset for a
// while longer and then releases it. Loss of lock in RUN restarts the sequence.
// Optional macro LOCK_LOSS_COUNTER_EN builds the saturating lock-loss counter;
// without it lock_loss_cnt is tied to zero and the state machine is unchanged.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int CNT_W               = 8
) (
  input logic                  clk,
  input logic                  rst,
  pll_reset_sequencer_if.master io_pll
);

  // One counter width covers every cycle count the sequencer has to reach.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNTR_W  = $clog2(MAX_ALL) + 1;

  localparam logic [CNTR_W-1:0] C_PLL_LAST  = CNTR_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNTR_W-1:0] C_STAB_LAST = CNTR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNTR_W-1:0] C_TMO_LAST  = CNTR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNTR_W-1:0] C_HOLD_LAST = CNTR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNTR_W-1:0] C_ONE       = CNTR_W'(1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNTR_W-1:0] r_cnt;
  logic [CNTR_W-1:0] r_stab;
  logic              r_sync_p0;
  logic              r_sync_p1;
  logic              r_pll_rst;
  logic              r_sys_rst;
  logic              r_ready;
  logic              w_locked_s;

  assign w_locked_s = r_sync_p1;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= io_pll.pll_locked;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Sequencer FSM; outputs are set on the edge that enters each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_stab    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == C_PLL_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_stab    <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WAIT_LOCK: begin
          // Acceptance is tested before the timeout so it wins a tie.
          if (w_locked_s && (r_stab == C_STAB_LAST)) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_stab  <= '0;
          end else if (r_cnt == C_TMO_LAST) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_stab    <= '0;
            r_pll_rst <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + C_ONE;
            r_stab <= w_locked_s ? (r_stab + C_ONE) : '0;
          end
        end
        S_HOLD: begin
          // A drop here only restarts debouncing; it is not a lock loss.
          if (!w_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_stab  <= '0;
          end else if (r_cnt == C_HOLD_LAST) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_PLL_RST;
          r_cnt     <= '0;
          r_stab    <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign io_pll.pll_rst = r_pll_rst;
  assign io_pll.sys_rst = r_sys_rst;
  assign io_pll.ready   = r_ready;

`ifdef LOCK_LOSS_COUNTER_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  logic             w_loss_evt;
  logic [CNT_W-1:0] r_loss_cnt;

  // Same condition the FSM uses to leave RUN, so the count moves on that edge.
  assign w_loss_evt = (r_state == S_RUN) && !w_locked_s;

  // Saturating count of lock losses observed while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt) begin
      r_loss_cnt <= sat_inc(r_loss_cnt);
    end
  end

  assign io_pll.lock_loss_cnt = r_loss_cnt;
`else
  assign io_pll.lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RST_HOLD_CYCLES=4, CNT_W=2.
// Cycle k counts posedges after the last edge with rst high; outputs are
// sampled 1 time unit after each edge, and the lock input is updated then.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pll_reset_sequencer_if #(.CNT_W(2)) u_if ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RST_HOLD_CYCLES     (4),
    .CNT_W               (2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_pll (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef LOCK_LOSS_COUNTER_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lock input applied after edge k for each scenario.
  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return (k % 7) != 6;
      2:       return k != 11;
      default: return !((k >= 20) && (k <= 24));
    endcase
  endfunction

  function automatic logic exp_pll_rst(input int mode, input int k);
    case (mode)
      0, 1:    return (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76);
      2:       return k < 4;
      default: return (k < 4) || (k >= 23 && k < 27);
    endcase
  endfunction

  function automatic logic exp_sys_rst(input int mode, input int k);
    case (mode)
      0, 1:    return 1'b1;
      2:       return k < 26;
      default: return (k < 16) || (k >= 23 && k < 39);
    endcase
  endfunction

  function automatic int exp_loss(input int mode, input int k);
    if (mode == 3 && k >= 23) return cnt_exp(1);
    return 0;
  endfunction

  task automatic do_reset(input int mode);
    rst = 1'b1;
    u_if.pll_locked = 1'b0;
    repeat (3) tick();
    check_val($sformatf("m%0d reset pll_rst", mode), 32'(u_if.pll_rst), 32'd1);
    check_val($sformatf("m%0d reset sys_rst", mode), 32'(u_if.sys_rst), 32'd1);
    check_val($sformatf("m%0d reset ready", mode), 32'(u_if.ready), 32'd0);
    check_val($sformatf("m%0d reset loss_cnt", mode), 32'(u_if.lock_loss_cnt), 32'd0);
    rst = 1'b0;
    u_if.pll_locked = pat(mode, 0);
  endtask

  task automatic run_mode(input int mode, input int n);
    do_reset(mode);
    for (int k = 1; k <= n; k++) begin
      tick();
      check_val($sformatf("m%0d k%0d pll_rst", mode, k), 32'(u_if.pll_rst), 32'(exp_pll_rst(mode, k)));
      check_val($sformatf("m%0d k%0d sys_rst", mode, k), 32'(u_if.sys_rst), 32'(exp_sys_rst(mode, k)));
      check_val($sformatf("m%0d k%0d ready", mode, k), 32'(u_if.ready), 32'(!exp_sys_rst(mode, k)));
      check_val($sformatf("m%0d k%0d loss_cnt", mode, k), 32'(u_if.lock_loss_cnt), 32'(exp_loss(mode, k)));
      u_if.pll_locked = pat(mode, k);
    end
  endtask

  // From RUN: drop lock 5 cycles, expect reset within 3, RUN again 19 cycles on.
  task automatic lose_and_relock(input int n_loss, input int exp_cnt);
    u_if.pll_locked = 1'b0;
    repeat (3) tick();
    check_val($sformatf("loss%0d sys_rst", n_loss), 32'(u_if.sys_rst), 32'd1);
    check_val($sformatf("loss%0d ready", n_loss), 32'(u_if.ready), 32'd0);
    check_val($sformatf("loss%0d pll_rst", n_loss), 32'(u_if.pll_rst), 32'd1);
    repeat (2) tick();
    u_if.pll_locked = 1'b1;
    repeat (14) tick();
    check_val($sformatf("loss%0d relock ready", n_loss), 32'(u_if.ready), 32'd1);
    check_val($sformatf("loss%0d relock sys_rst", n_loss), 32'(u_if.sys_rst), 32'd0);
    check_val($sformatf("loss%0d relock pll_rst", n_loss), 32'(u_if.pll_rst), 32'd0);
    check_val($sformatf("loss%0d loss_cnt", n_loss), 32'(u_if.lock_loss_cnt), 32'(exp_cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    u_if.pll_locked = 1'b0;

    run_mode(0, 80);  // lock never asserts: periodic PLL re-reset
    run_mode(1, 40);  // 6 high / 1 low: timeout re-reset
    run_mode(2, 30);  // drop during HOLD: back to WAIT_LOCK
    run_mode(3, 45);  // steady lock to RUN, then one loss and relock

    lose_and_relock(2, cnt_exp(2));
    lose_and_relock(3, cnt_exp(3));
    lose_and_relock(4, cnt_exp(3));
    lose_and_relock(5, cnt_exp(3));

    // Reset asserted while running.
    rst = 1'b1;
    tick();
    check_val("midrun rst pll_rst", 32'(u_if.pll_rst), 32'd1);
    check_val("midrun rst sys_rst", 32'(u_if.sys_rst), 32'd1);
    check_val("midrun rst ready", 32'(u_if.ready), 32'd0);
    check_val("midrun rst loss_cnt", 32'(u_if.lock_loss_cnt), 32'd0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Clocked from the free-running 50 MHz board reference, i.e. the same clock that feeds the PLL.
- Drives the PLL reset input and consumes the PLL lock indication.
- Generates a clean, registered, active-high system reset (`sys_rst`) for logic in the PLL output domains; that reset is released only after a debounced, stable lock.
- Recovers from lock loss: re-resets the PLL and re-asserts `sys_rst`.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per PLL reset pulse (min 1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before lock is accepted (min 1).
- LOCK_TIMEOUT_CYCLES, 65536: max cycles in WAIT_LOCK before the PLL is re-reset; must be greater than LOCK_STABLE_CYCLES.
- RST_HOLD_CYCLES, 64: cycles `sys_rst` stays high after lock is accepted (min 1).
- CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk  in  1  free-running reference clock (50 MHz)
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- pll_rst  out  1  reset to the PLL, active-high, registered
- sys_rst  out  1  system reset for PLL clock domains, active-high, registered
- ready  out  1  high while in RUN
- lock_loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN

Behaviour:
- Synchronizer: `pll_locked` passes through 2 flops to form `locked_s`; all decisions use `locked_s` only.
- One state counter, sized as $clog2 of the largest parameter + 1. It clears on every state entry.
- Reset (`rst`=1 at a clk edge):
  - state = PLL_RST, counter = 0, synchronizer flops = 0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `lock_loss_cnt`=0.
  - `rst` held across any state aborts to these values at the next edge.
- States:
  - PLL_RST:
    - `pll_rst`=1, `sys_rst`=1.
    - Exits to WAIT_LOCK after exactly PLL_RST_CYCLES cycles in the state.
    - After `rst` deasserts, `pll_rst` is therefore high for exactly PLL_RST_CYCLES cycles.
  - WAIT_LOCK:
    - `pll_rst`=0, `sys_rst`=1.
    - Stability counter increments on `locked_s`=1 and clears on `locked_s`=0.
    - When the stability count reaches LOCK_STABLE_CYCLES, go to HOLD.
    - Separate timeout counter: on reaching LOCK_TIMEOUT_CYCLES without acceptance, go to PLL_RST.
    - If both conditions hit the same cycle, lock acceptance wins.
  - HOLD:
    - `pll_rst`=0, `sys_rst`=1.
    - After RST_HOLD_CYCLES cycles, go to RUN.
    - `locked_s`=0 during HOLD returns to WAIT_LOCK with counters cleared; this is not counted as a lock loss.
  - RUN:
    - `sys_rst`=0, `ready`=1. `sys_rst` deasserts on the same edge the state becomes RUN.
    - `locked_s`=0 goes to PLL_RST. On that same edge: `sys_rst`=1, `ready`=0, `pll_rst`=1, and `lock_loss_cnt` increments.
    - `lock_loss_cnt` saturates at 2^CNT_W-1; it never wraps.
- Latencies:
  - Lock drop on `pll_locked` to `sys_rst` high: ≤3 clk (2 synchronizer + 1 registered output).
  - Lock acceptance: LOCK_STABLE_CYCLES consecutive high `locked_s` cycles.
- Glitches: a `pll_locked` pulse shorter than 1 clk may or may not be seen.
  - If seen in WAIT_LOCK, it only restarts stability counting.
  - If seen in RUN, it is treated as a real loss.
- All outputs are driven directly from flops, with no combinational paths from inputs.

Optional Feature:
- LOCK_LOSS_COUNTER_EN
  - Defined: the `lock_loss_cnt` register is implemented as described above.
  - Undefined: no counter flops are built; `lock_loss_cnt` is tied to 0; the state machine is unchanged.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RST_HOLD_CYCLES=4, CNT_W=2.
- Reset then steady lock:
  - Stimulus: `rst` high 3 cycles; `pll_locked`=1 from the cycle `rst` falls.
  - Response: `pll_rst` high exactly 4 cycles after `rst` falls; `sys_rst` falls and `ready` rises together 4+8+4 (+synchronizer) cycles later; `lock_loss_cnt`=0.
- Lock never asserts:
  - Stimulus: `pll_locked`=0 throughout.
  - Response: `pll_rst` pulses high for 4 cycles every 36 cycles; `sys_rst` stays 1; `ready` stays 0.
- Unstable lock:
  - Stimulus: `pll_locked` toggles 6 cycles high / 1 low.
  - Response: never reaches HOLD; timeout re-reset after 32 cycles in WAIT_LOCK.
- Loss in RUN:
  - Stimulus: drop `pll_locked` for 5 cycles while in RUN.
  - Response: `sys_rst`=1 and `ready`=0 within 3 cycles; `pll_rst` high 4 cycles; `lock_loss_cnt`=1; re-enters RUN after relock.
- Saturation: 5 losses in RUN → `lock_loss_cnt`=3. With LOCK_LOSS_COUNTER_EN undefined → `lock_loss_cnt` reads 0 throughout.
- Loss during HOLD, and `rst` mid-RUN:
  - Drop `pll_locked` in HOLD → back to WAIT_LOCK; `lock_loss_cnt` unchanged; `sys_rst` never low.
  - Assert `rst` mid-RUN → all outputs at reset values on the next edge.
